// File: rtl/uart_cmd_decoder.sv
// Frames a UART byte stream (header, opcode, A, B, XOR checksum) into ALU commands.
// Outputs update only on a complete valid frame; bad or stalled frames raise an error pulse.
module uart_cmd_decoder #(
  parameter logic [7:0]  HEADER         = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 21700
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [3:0] alu_op,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic       cmd_valid,
  output logic       err_frame,
  output logic       err_timeout,
  output logic       busy
);

  localparam int unsigned    CntW   = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {StIdle, StGetOp, StGetA, StGetB, StGetChk} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [7:0]      op_tmp_q, a_tmp_q, b_tmp_q;
  logic [7:0]      chk_exp;

  assign chk_exp = op_tmp_q ^ a_tmp_q ^ b_tmp_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      op_tmp_q    <= '0;
      a_tmp_q     <= '0;
      b_tmp_q     <= '0;
      alu_op      <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      cmd_valid   <= 1'b0;
      err_frame   <= 1'b0;
      err_timeout <= 1'b0;
      busy        <= 1'b0;
    end else begin
      cmd_valid   <= 1'b0;
      err_frame   <= 1'b0;
      err_timeout <= 1'b0;
      if (state_q == StIdle) begin
        cnt_q <= '0;
        if (rx_valid && rx_data == HEADER) begin
          state_q <= StGetOp;
          busy    <= 1'b1;
        end
      end else if (rx_valid) begin
        // An arriving byte always beats a timeout expiring in the same cycle.
        cnt_q <= '0;
        case (state_q)
          StGetOp: begin
            op_tmp_q <= rx_data;
            state_q  <= StGetA;
          end
          StGetA: begin
            a_tmp_q <= rx_data;
            state_q <= StGetB;
          end
          StGetB: begin
            b_tmp_q <= rx_data;
            state_q <= StGetChk;
          end
          StGetChk: begin
            if (rx_data == chk_exp && op_tmp_q[7:4] == 4'h0) begin
              alu_op    <= op_tmp_q[3:0];
              alu_a     <= a_tmp_q;
              alu_b     <= b_tmp_q;
              cmd_valid <= 1'b1;
            end else begin
              err_frame <= 1'b1;
            end
            state_q <= StIdle;
            busy    <= 1'b0;
          end
          default: begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end
        endcase
      end else if (cnt_q == CntMax) begin
        err_timeout <= 1'b1;
        state_q     <= StIdle;
        busy        <= 1'b0;
        cnt_q       <= '0;
        op_tmp_q    <= '0;
        a_tmp_q     <= '0;
        b_tmp_q     <= '0;
      end else begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Scoreboard bench for uart_cmd_decoder: stimulus queues expected pulses, a negedge monitor
// pops and checks kind, arrival cycle and ALU outputs.
module tb_uart_cmd_decoder;

  localparam int unsigned Timeout = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [3:0] alu_op;
  logic [7:0] alu_a, alu_b;
  logic       cmd_valid, err_frame, err_timeout, busy;

  uart_cmd_decoder #(
    .HEADER        (8'hA5),
    .TIMEOUT_CYCLES(Timeout)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .cmd_valid  (cmd_valid),
    .err_frame  (err_frame),
    .err_timeout(err_timeout),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // vec is {cmd_valid, err_frame, err_timeout}
  typedef struct {
    logic [2:0]  vec;
    int unsigned cyc;
    logic [3:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
  } ev_t;

  ev_t        sb_q[$];
  ev_t        mon_e;
  logic [3:0] m_op = 4'h0;
  logic [7:0] m_a = 8'h00, m_b = 8'h00;
  int         errors = 0;
  int         checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [2:0] vec, input int unsigned delay);
    ev_t e;
    e.vec = vec;
    e.cyc = cyc + delay;
    e.op  = m_op;
    e.a   = m_a;
    e.b   = m_b;
    sb_q.push_back(e);
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  // Sends a full frame; the expected outcome is queued just before the checksum strobe.
  task automatic frame(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic good);
    send(8'hA5);
    send(op);
    send(a);
    send(b);
    if (good) begin
      m_op = op[3:0];
      m_a  = a;
      m_b  = b;
      push(3'b100, 1);
    end else begin
      push(3'b010, 1);
    end
    send(c);
  endtask

  always @(negedge clk) begin
    if (!rst && (cmd_valid || err_frame || err_timeout)) begin
      if (sb_q.size() == 0) begin
        chk("unexpected pulse", {29'd0, cmd_valid, err_frame, err_timeout}, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("pulse kind", {29'd0, cmd_valid, err_frame, err_timeout}, {29'd0, mon_e.vec});
        chk("pulse cycle", cyc, mon_e.cyc);
        chk("alu_op", {28'd0, alu_op}, {28'd0, mon_e.op});
        chk("alu_a", {24'd0, alu_a}, {24'd0, mon_e.a});
        chk("alu_b", {24'd0, alu_b}, {24'd0, mon_e.b});
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset outputs", {alu_op, alu_a, alu_b}, 32'd0);
    chk("reset pulses/busy", {28'd0, cmd_valid, err_frame, err_timeout, busy}, 32'd0);

    // Bad checksum: outputs stay at reset values
    frame(8'h03, 8'h12, 8'h34, 8'h26, 1'b0);
    chk("busy after bad frame", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);

    // Valid frame
    frame(8'h03, 8'h12, 8'h34, 8'h25, 1'b1);
    chk("busy after good frame", {31'd0, busy}, 32'd0);

    // Illegal opcode, back-to-back with previous frame
    frame(8'h13, 8'h00, 8'h00, 8'h13, 1'b0);

    // Leading garbage then frame with embedded header bytes
    send(8'h00);
    send(8'hFF);
    chk("busy ignores garbage", {31'd0, busy}, 32'd0);
    send(8'hA5);
    chk("busy after header", {31'd0, busy}, 32'd1);
    send(8'h01);
    send(8'hA5);
    send(8'hA5);
    m_op = 4'h1;
    m_a  = 8'hA5;
    m_b  = 8'hA5;
    push(3'b100, 1);
    send(8'h01);
    repeat (2) @(negedge clk);

    // Timeout: expires 17 clocks after the last strobe
    send(8'hA5);
    push(3'b001, Timeout + 2);
    send(8'h02);
    repeat (Timeout) @(negedge clk);
    chk("busy before expiry", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("busy after timeout", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    frame(8'h04, 8'h55, 8'hAA, 8'hFB, 1'b1);

    // Bytes landing exactly on the expiry cycle win over the timeout
    send(8'hA5);
    send(8'h02);
    repeat (Timeout) @(negedge clk);
    send(8'h10);
    repeat (Timeout) @(negedge clk);
    send(8'h20);
    chk("busy after late byte", {31'd0, busy}, 32'd1);
    m_op = 4'h2;
    m_a  = 8'h10;
    m_b  = 8'h20;
    push(3'b100, 1);
    send(8'h32);
    repeat (2) @(negedge clk);

    // Reset mid-frame discards the frame and clears outputs
    send(8'hA5);
    send(8'h03);
    send(8'h12);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_op = 4'h0;
    m_a  = 8'h00;
    m_b  = 8'h00;
    chk("busy after reset", {31'd0, busy}, 32'd0);
    send(8'h34);
    send(8'h25);
    repeat (2) @(negedge clk);
    chk("outputs after reset", {alu_op, alu_a, alu_b}, 32'd0);
    chk("busy idle after reset", {31'd0, busy}, 32'd0);
    frame(8'h05, 8'h0F, 8'hF0, 8'hFA, 1'b1);

    repeat (5) @(negedge clk);
    chk("pending events", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
